// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-access stage between EX/MEM and the data SRAM. Issues
//            lane-aligned SRAM strobes for stores and loads, waits out the
//            one-cycle SRAM read latency and extends load data into a
//            registered writeback result. Misaligned accesses are trapped
//            without touching the SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  // upstream handshake and instruction fields
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        wb_en,
  // data SRAM
  output logic        sram_cs,
  output logic        sram_oe,
  output logic [3:0]  sram_web,
  output logic [13:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  // writeback result
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_misalign
);

  // Access type on mem_op[4:3]
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  // Access size on mem_op[1:0]
  localparam logic [1:0] MEM_BYTE  = 2'b00;
  localparam logic [1:0] MEM_HALF  = 2'b01;
  localparam logic [1:0] MEM_WORD  = 2'b10;

  // FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;

  // Load context captured at accept, consumed in RD_WAIT
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_q, wb_d;

  // Result register
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_wb_en_q, out_wb_en_d;
  logic        out_mis_q, out_mis_d;

  // Decode of the incoming instruction
  logic [1:0]  w_op;
  logic [1:0]  w_size;
  logic        w_is_read;
  logic        w_is_write;
  logic        w_misalign;
  logic        w_accept;
  logic        w_access;
  logic        w_start_load;
  logic [3:0]  w_byte_sel;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  assign w_op       = mem_op[4:3];
  assign w_size     = mem_op[1:0];
  // Encoding 2'b11 on mem_op[4:3] falls through as a non-memory op
  assign w_is_read  = (w_op == MEM_READ);
  assign w_is_write = (w_op == MEM_WRITE);

  // Only real memory accesses can be misaligned; byte accesses never are
  assign w_misalign = (w_is_read || w_is_write) &&
                      (((w_size == MEM_HALF) && addr[0]) ||
                       ((w_size == MEM_WORD) && (addr[1:0] != 2'b00)));

  assign in_ready     = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign w_accept     = in_valid && in_ready;
  // Reset suppresses any SRAM activity even if upstream is presenting work
  assign w_access     = w_accept && !rst && (w_is_read || w_is_write) && !w_misalign;
  assign w_start_load = w_access && w_is_read;

  // Combinational SRAM strobes, asserted only in the accept cycle
  always_comb begin
    sram_cs    = 1'b0;
    sram_oe    = 1'b0;
    sram_web   = 4'hF;
    sram_addr  = 14'd0;
    sram_din   = 32'd0;
    w_byte_sel = 4'b0001 << addr[1:0];
    if (w_access) begin
      sram_cs   = 1'b1;
      sram_addr = addr[15:2];
      if (w_is_read) begin
        sram_oe = 1'b1;
      end else begin
        case (w_size)
          MEM_BYTE: begin
            sram_web = ~w_byte_sel;
            sram_din = {4{store_data[7:0]}};
          end
          MEM_HALF: begin
            sram_web = addr[1] ? 4'b0011 : 4'b1100;
            sram_din = {2{store_data[15:0]}};
          end
          default: begin
            sram_web = 4'b0000;
            sram_din = store_data;
          end
        endcase
      end
    end
  end

  // Lane select and sign/zero extension of the returning read data
  always_comb begin
    w_ld_byte = sram_dout[{off_q, 3'b000} +: 8];
    w_ld_half = off_q[1] ? sram_dout[31:16] : sram_dout[15:0];
    case (size_q)
      MEM_BYTE: w_ld_data = uns_q ? {24'd0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      MEM_HALF: w_ld_data = uns_q ? {16'd0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      default:  w_ld_data = sram_dout;
    endcase
  end

  // Next-state for the FSM, load context and result register
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_wb_en_d = out_wb_en_q;
    out_mis_d   = out_mis_q;

    case (state_q)
      ST_RD_WAIT: begin
        // Entry guaranteed a free slot, so the result always lands here
        out_valid_d = 1'b1;
        out_data_d  = w_ld_data;
        out_rd_d    = rd_q;
        out_wb_en_d = wb_q;
        out_mis_d   = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        if (w_start_load) begin
          off_d   = addr[1:0];
          size_d  = w_size;
          uns_d   = mem_op[2];
          rd_d    = rd;
          wb_d    = wb_en;
          state_d = ST_RD_WAIT;
          if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end else if (w_accept) begin
          // Stores, non-memory ops and trapped accesses finish immediately
          out_valid_d = 1'b1;
          out_data_d  = addr;
          out_rd_d    = rd;
          out_wb_en_d = wb_en && !w_is_write && !w_misalign;
          out_mis_d   = w_misalign;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      rd_q        <= 5'd0;
      wb_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_rd_q    <= 5'd0;
      out_wb_en_q <= 1'b0;
      out_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_wb_en_q <= out_wb_en_d;
      out_mis_q   <= out_mis_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign out_wb_en    = out_wb_en_q;
  assign out_misalign = out_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A behavioural SRAM
//            answers the DUT; a byte-addressed reference memory predicts
//            strobes and load results from the access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  mem_op = 5'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        wb_en = 1'b0;
  logic        sram_cs;
  logic        sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  // Behavioural SRAM (16 words) and byte-level reference image (64 bytes)
  bit [31:0] sram_mem [16];
  bit [7:0]  ref_mem  [64];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data), .rd(rd), .wb_en(wb_en),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle registered read and per-lane writes
  always @(posedge clk) begin
    if (sram_cs && sram_oe) begin
      sram_dout <= sram_mem[sram_addr[3:0]];
    end else if (sram_cs) begin
      for (int j = 0; j < 4; j++)
        if (!sram_web[j]) sram_mem[sram_addr[3:0]][8*j +: 8] <= sram_din[8*j +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] a);
    return ((size == 2'd1) && a[0]) || ((size == 2'd2) && (a[1:0] != 2'b00));
  endfunction

  // Lanes written by an aligned store of 1, 2 or 4 bytes starting at a
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [31:0] a);
    int n = 1 << size;
    logic [3:0] m = 4'd0;
    for (int k = 0; k < n; k++) m[int'(a[1:0]) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'd0:    return {4{sd[7:0]}};
      2'd1:    return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] sd);
    int n = 1 << size;
    for (int k = 0; k < n; k++) ref_mem[(int'(a[5:0]) + k) % 64] = sd[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] a);
    int n = 1 << size;
    longint v = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[(int'(a[5:0]) + k) % 64]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_rd, out_wb_en, out_misalign} !== 40'd0) begin
      errors++;
      $display("FAIL reset_result: got v=%0b d=%h rd=%0d wb=%0b mis=%0b, required all zero",
               out_valid, out_data, out_rd, out_wb_en, out_misalign);
    end
    checks++;
    if ({sram_cs, sram_oe, sram_web, sram_addr, sram_din} !== {2'b00, 4'hF, 14'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_sram: got cs=%0b oe=%0b web=%b addr=%h din=%h, required 0 0 1111 0 0",
               sram_cs, sram_oe, sram_web, sram_addr, sram_din);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Directed access patterns followed by randomized traffic
  task automatic test_ops(input int n_rand);
    localparam int N_DIR = 11;
    logic [4:0]  d_op   [N_DIR] = '{5'b10_0_10, 5'b01_0_00, 5'b01_1_00, 5'b10_0_10, 5'b01_0_01,
                                    5'b01_1_01, 5'b10_0_00, 5'b01_1_00, 5'b10_0_10, 5'b01_0_10,
                                    5'b11_0_00};
    logic [31:0] d_addr [N_DIR] = '{32'h200, 32'h202, 32'h202, 32'h4, 32'h6,
                                    32'h6, 32'h103, 32'h103, 32'h8, 32'h5,
                                    32'h1234_5677};
    logic [31:0] d_sd   [N_DIR] = '{32'h0080_0000, 32'h0, 32'h0, 32'h8001_1234, 32'h0,
                                    32'h0, 32'h0000_00AB, 32'h0, 32'hCAFE_F00D, 32'h0,
                                    32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < N_DIR + n_rand; i++) begin : txn
      logic [4:0]  op;
      logic [31:0] a, sd, exp_d;
      logic [4:0]  r;
      logic        w, is_rd, is_wr, mis, acc, exp_wb;
      logic [1:0]  size;
      if (i < N_DIR) begin
        op = d_op[i]; a = d_addr[i]; sd = d_sd[i];
      end else begin
        size = 2'($urandom_range(0, 2));
        op   = {2'($urandom_range(0, 3)), 1'($urandom), size};
        a    = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 32'd1);
        sd   = $urandom;
      end
      r     = 5'($urandom);
      w     = 1'($urandom);
      size  = op[1:0];
      is_rd = (op[4:3] == 2'b01);
      is_wr = (op[4:3] == 2'b10);
      mis   = (is_rd || is_wr) && misaligned(size, a);
      acc   = (is_rd || is_wr) && !mis;

      @(posedge clk); #1;
      in_valid = 1'b1; mem_op = op; addr = a; store_data = sd; rd = r; wb_en = w;
      @(negedge clk);
      checks++;
      if ({in_ready, sram_cs, sram_oe, sram_web} !==
          {1'b1, acc, acc && is_rd, (acc && is_wr) ? ~lane_mask(size, a) : 4'hF}) begin
        errors++;
        $display("FAIL strobe[%0d] op=%b a=%h: got rdy=%0b cs=%0b oe=%0b web=%b, required 1 %0b %0b %b",
                 i, op, a, in_ready, sram_cs, sram_oe, sram_web, acc, acc && is_rd,
                 (acc && is_wr) ? ~lane_mask(size, a) : 4'hF);
      end
      if (acc) begin
        checks++;
        if (sram_addr !== a[15:2] || (is_wr && sram_din !== lane_data(size, sd))) begin
          errors++;
          $display("FAIL sram_bus[%0d] op=%b a=%h: got addr=%h din=%h, required addr=%h din=%h",
                   i, op, a, sram_addr, sram_din, a[15:2], lane_data(size, sd));
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (acc && is_wr) ref_store(size, a, sd);
      exp_wb = (is_wr || mis) ? 1'b0 : w;
      exp_d  = a;
      if (acc && is_rd) begin
        exp_d = ref_load(size, op[2], a);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, sram_cs} !== 3'b000) begin
          errors++;
          $display("FAIL rd_wait[%0d]: got v=%0b rdy=%0b cs=%0b, required 0 0 0",
                   i, out_valid, in_ready, sram_cs);
        end
        @(posedge clk);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_rd, out_wb_en, out_misalign} !== {1'b1, r, exp_wb, mis} ||
          (!(acc && is_wr) && out_data !== exp_d)) begin
        errors++;
        $display("FAIL result[%0d] op=%b a=%h: got v=%0b d=%h rd=%0d wb=%0b mis=%0b, required 1 d=%h rd=%0d wb=%0b mis=%0b",
                 i, op, a, out_valid, out_data, out_rd, out_wb_en, out_misalign, exp_d, r, exp_wb, mis);
      end
    end
  endtask

  // Non-memory ops stream at one per cycle
  task automatic test_back_to_back();
    logic [31:0] pa;
    logic [4:0]  pr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [4:0]  r;
      a = $urandom; r = 5'($urandom);
      in_valid = 1'b1; mem_op = 5'b00_0_10; addr = a; rd = r; wb_en = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || (i > 0 && (out_valid !== 1'b1 || out_data !== pa || out_rd !== pr))) begin
        errors++;
        $display("FAIL b2b[%0d]: got rdy=%0b v=%0b d=%h rd=%0d, required 1 1 d=%h rd=%0d",
                 i, in_ready, out_valid, out_data, out_rd, pa, pr);
      end
      pa = a; pr = r;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Stall with a pending result, then consume and accept in one cycle
  task automatic test_back_pressure();
    logic [31:0] a;
    a = $urandom;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; mem_op = 5'b00_0_00; addr = a; rd = 5'd3; wb_en = 1'b1;
    @(posedge clk); #1;
    mem_op = 5'b10_0_10; addr = 32'h10; store_data = 32'h5A5A_C3C3; rd = 5'd7; wb_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, sram_cs, out_valid, out_data, out_rd, out_wb_en} !== {2'b00, 1'b1, a, 5'd3, 1'b1}) begin
        errors++;
        $display("FAIL stall[%0d]: got rdy=%0b cs=%0b v=%0b d=%h rd=%0d wb=%0b, required 0 0 1 d=%h rd=3 wb=1",
                 c, in_ready, sram_cs, out_valid, out_data, out_rd, out_wb_en, a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, sram_cs, sram_web} !== {2'b11, 4'b0000}) begin
      errors++;
      $display("FAIL release: got rdy=%0b cs=%0b web=%b, required 1 1 0000", in_ready, sram_cs, sram_web);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ref_store(2'd2, 32'h10, 32'h5A5A_C3C3);
    @(negedge clk);
    checks++;
    if ({out_valid, out_rd, out_wb_en, out_misalign} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL release_result: got v=%0b rd=%0d wb=%0b mis=%0b, required 1 7 0 0",
               out_valid, out_rd, out_wb_en, out_misalign);
    end
  endtask

  // Reset during RD_WAIT abandons the load; next load runs normally
  task automatic test_rst_rd_wait();
    logic [31:0] e;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = 5'b01_0_10; addr = 32'h8; rd = 5'd9; wb_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, sram_cs, sram_web} !== {3'b010, 4'hF}) begin
      errors++;
      $display("FAIL rst_rd_wait: got v=%0b rdy=%0b cs=%0b web=%b, required 0 1 0 1111",
               out_valid, in_ready, sram_cs, sram_web);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = 5'b01_1_00; addr = 32'h9; rd = 5'd4; wb_en = 1'b1;
    e = ref_load(2'd0, 1'b1, 32'h9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_t1: got v=%0b, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_rd, out_wb_en} !== {1'b1, e, 5'd4, 1'b1}) begin
      errors++;
      $display("FAIL post_rst_load: got v=%0b d=%h rd=%0d wb=%0b, required 1 d=%h rd=4 wb=1",
               out_valid, out_data, out_rd, out_wb_en, e);
    end
  endtask

  initial begin
    test_reset();
    test_ops(300);
    test_back_to_back();
    test_back_pressure();
    test_rst_rd_wait();
    test_ops(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
